data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the multi-cycle processor's data port: accepts one load/store
//  request at a time over a valid/ready handshake, models LATENCY wait states, then returns
//  a response (read data or write ack) over a second valid/ready handshake. Owns the data
//  storage array and replaces the zero-latency data memory when the core runs multi-cycle.
// PARAMETERS
//  width       32  data word width in bits
//  wordLength  32  number of words in the array (power of two); address width AW = $clog2(wordLength)
//  LATENCY     2   wait-state cycles between request acceptance and the response (0..15)
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      asynchronous, active-low reset (0 = reset)
//  req_valid   in   1      requester presents a request
//  req_ready   out  1      responder can accept; high only in IDLE
//  req_write   in   1      1 = store, 0 = load
//  req_addr    in   AW     word address
//  req_wdata   in   width  store data
//  resp_valid  out  1      response available
//  resp_ready  in   1      requester takes the response
//  resp_write  out  1      1 = response is a store ack, 0 = load data
//  resp_rdata  out  width  load data (store ack: the value now held at the address)
//  busy        out  1      high from acceptance until response is taken (state != IDLE)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, req_ready=1, resp_valid=0, resp_write=0, resp_rdata=0,
//    busy=0, wait counter=0. Array contents are NOT cleared by reset.
//  - FSM states IDLE, WAIT, RESP.
//    IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata; go WAIT with
//          counter=LATENCY-1 if LATENCY>0, else straight to RESP.
//    WAIT: counter decrements each cycle; when counter==0 go RESP next edge.
//          req_valid ignored (req_ready=0); inputs may change without effect.
//    RESP: resp_valid=1, resp_write/resp_rdata stable until resp_ready=1; on
//          resp_valid&resp_ready go IDLE. resp_ready held low stalls indefinitely.
//  - Accept-to-resp_valid latency = LATENCY+1 cycles (LATENCY=0 -> resp_valid the cycle after accept).
//  - Store commits to the array on the edge that enters RESP; load samples the array on the
//    same edge. Only latched request fields are used; live inputs after acceptance are ignored.
//  - Store ack: resp_rdata = stored wdata.
//  - One bubble between transactions: req_ready rises the cycle after the response handshake.
//  - Reset mid-operation: transaction aborted; a store still in WAIT is NOT committed;
//    a store already in RESP has committed and stays in the array.
//  - req_valid may be asserted any time; it is only sampled in IDLE. No address range
//    check needed (AW covers exactly wordLength words).
//  - resp_rdata holds its last value in IDLE/WAIT (not cleared between transactions).
// TESTING
//  1 Reset: rst=0 mid-cycle -> immediately req_ready=1, resp_valid=0, busy=0, resp_rdata=0.
//  2 Store then load, LATENCY=2: store addr 5 data 0xDEADBEEF -> resp_valid 3 cycles after accept,
//    resp_write=1, rdata=0xDEADBEEF; load addr 5 -> resp_write=0, rdata=0xDEADBEEF after 3 cycles.
//  3 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata stable, req_ready=0;
//    new req_valid with addr 7 ignored; release -> IDLE next cycle, req_ready=1.
//  4 LATENCY=0 build: load addr 0 (preloaded 0x12345678) -> resp_valid the cycle after accept.
//  5 Input stability: change req_addr/req_wdata during WAIT -> response uses latched
//    addr 3/data 0xA5A5A5A5 only; addr of changed value unmodified.
//  6 Reset during WAIT of store to addr 9 (old value 0x1) -> after reset, load addr 9 returns 0x1.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port memory responder with request/response handshakes and wait states
module data_mem_responder #(
    parameter int width      = 32,
    parameter int wordLength = 32,
    parameter int LATENCY    = 2,
    localparam int AW        = $clog2(wordLength)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [width-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_write,
    output logic [width-1:0] resp_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t             state, state_next;
    logic [3:0]         cnt;
    logic               lat_write;
    logic [AW-1:0]      lat_addr;
    logic [width-1:0]   lat_wdata;
    logic [width-1:0]   mem [wordLength];

    logic               accept;
    logic               enter_resp;
    logic               eff_write;
    logic [AW-1:0]      eff_addr;
    logic [width-1:0]   eff_wdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign accept     = req_valid && (state == IDLE);

    // With zero latency the array is accessed on the accept edge, so the live request is used.
    assign eff_write  = (state == IDLE) ? req_write : lat_write;
    assign eff_addr   = (state == IDLE) ? req_addr  : lat_addr;
    assign eff_wdata  = (state == IDLE) ? req_wdata : lat_wdata;

    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_write <= eff_write;
                resp_rdata <= eff_write ? eff_wdata : mem[eff_addr];
            end
        end
    end

    // Storage is not reset; gating with rst keeps an aborted store out of the array.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && eff_write) mem[eff_addr] <= eff_wdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder, LATENCY=2 and LATENCY=0 builds
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        rv2 = 1'b0, rv0 = 1'b0;
    logic        rr2, rr0, vv2, vv0, rw2, rw0, b2, b0;
    logic [31:0] rd2, rd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.width(32), .wordLength(32), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rr2), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vv2), .resp_ready(resp_ready),
        .resp_write(rw2), .resp_rdata(rd2), .busy(b2)
    );

    data_mem_responder #(.width(32), .wordLength(32), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vv0), .resp_ready(resp_ready),
        .resp_write(rw0), .resp_rdata(rd0), .busy(b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input bit sel, input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd, input int hold, input string tag);
        int n;
        logic [31:0] held;
        @(negedge clk);
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        if (sel) rv0 = 1'b1; else rv2 = 1'b1;
        check({tag, "_ready"}, {31'd0, sel ? rr0 : rr2}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                rv0 = 1'b0;
                rv2 = 1'b0;
                req_addr  = ~addr;
                req_wdata = ~wd;
                req_write = ~wr;
            end
        end while (!(sel ? vv0 : vv2) && n < 20);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_wr"}, {31'd0, sel ? rw0 : rw2}, {31'd0, wr});
        check({tag, "_rdata"}, sel ? rd0 : rd2, exp_rd);
        held = sel ? rd0 : rd2;
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                req_write = 1'b1;
                req_addr  = 5'd7;
                req_wdata = 32'h0000_0BAD;
                if (sel) rv0 = 1'b1; else rv2 = 1'b1;
            end
            @(negedge clk);
            check({tag, "_stall_v"}, {31'd0, sel ? vv0 : vv2}, 32'd1);
            check({tag, "_stall_rd"}, sel ? rd0 : rd2, held);
            check({tag, "_stall_rdy"}, {31'd0, sel ? rr0 : rr2}, 32'd0);
        end
        rv0 = 1'b0;
        rv2 = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_idle_v"}, {31'd0, sel ? vv0 : vv2}, 32'd0);
        check({tag, "_idle_rdy"}, {31'd0, sel ? rr0 : rr2}, 32'd1);
    endtask

    initial begin
        // reset asserted mid-cycle must act immediately
        #13 rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, rr2}, 32'd1);
        check("rst_valid", {31'd0, vv2}, 32'd0);
        check("rst_busy", {31'd0, b2}, 32'd0);
        check("rst_rdata", rd2, 32'd0);
        check("rst_wr", {31'd0, rw2}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        txn(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3, 32'hDEADBEEF, 0, "st5");
        txn(1'b0, 1'b0, 5'd5, 32'h0, 3, 32'hDEADBEEF, 0, "ld5");

        // input stability: 28 is the inverted address driven during WAIT of the store to 3
        txn(1'b0, 1'b1, 5'd28, 32'h11111111, 3, 32'h11111111, 0, "st28");
        txn(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 3, 32'hA5A5A5A5, 0, "st3");
        txn(1'b0, 1'b0, 5'd3, 32'h0, 3, 32'hA5A5A5A5, 0, "ld3");
        txn(1'b0, 1'b0, 5'd28, 32'h0, 3, 32'h11111111, 0, "ld28");

        // backpressure with an intruding store to addr 7
        txn(1'b0, 1'b1, 5'd7, 32'h00000077, 3, 32'h00000077, 0, "st7");
        txn(1'b0, 1'b0, 5'd5, 32'h0, 3, 32'hDEADBEEF, 5, "bp5");
        txn(1'b0, 1'b0, 5'd7, 32'h0, 3, 32'h00000077, 0, "ld7");

        // zero-latency build
        txn(1'b1, 1'b1, 5'd0, 32'h12345678, 1, 32'h12345678, 0, "z_st0");
        txn(1'b1, 1'b0, 5'd0, 32'h0, 1, 32'h12345678, 0, "z_ld0");

        // reset during WAIT of a store must not commit it
        txn(1'b0, 1'b1, 5'd9, 32'h00000001, 3, 32'h00000001, 0, "st9");
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 5'd9;
        req_wdata = 32'hFFFF0000;
        rv2 = 1'b1;
        @(negedge clk);
        rv2 = 1'b0;
        check("abort_busy_pre", {31'd0, b2}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, b2}, 32'd0);
        check("abort_ready", {31'd0, rr2}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 1'b0, 5'd9, 32'h0, 3, 32'h00000001, 0, "ld9");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
